decode_queue: RTL

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_queue.sv
// Instruction queue with combinational RV32I/RV32E decode and register-file read of the head entry.
// Optional feature: define DECODE_QUEUE_WB_BYPASS_EN to forward a same-cycle write-back to rs1/rs2 data.
module decode_queue #(
   parameter int DEPTH    = 4,
   parameter int NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] inst_i,
   input  logic        wb_rd_write_en_i,
   input  logic [4:0]  wb_rd_id_i,
   input  logic [31:0] wb_rd_write_data_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [4:0]  decode_rs1_id_o,
   output logic [4:0]  decode_rs2_id_o,
   output logic [4:0]  decode_rd_id_o,
   output logic [11:0] decode_csr_id_o,
   output logic [9:0]  decode_opcode_info_o,
   output logic [5:0]  decode_branch_info_o,
   output logic [7:0]  decode_load_store_info_o,
   output logic [5:0]  decode_csr_info_o,
   output logic [2:0]  decode_sys_info_o,
   output logic        decode_illegal_o,
   output logic        decode_rd_write_en_o,
   output logic [31:0] decode_imm_o,
   output logic [31:0] regfile_rs1_rdata_o,
   output logic [31:0] regfile_rs2_rdata_o
);
   localparam int PW  = $clog2(DEPTH);
   localparam int RIW = $clog2(NUM_REGS);

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // ---------------- instruction FIFO ----------------
   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW:0]   count;
   logic          push, pop;

   assign in_ready_o  = (count != (PW+1)'(DEPTH));
   assign out_valid_o = (count != '0);
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;

   always_ff @(posedge clk) begin
      if (!rst || flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: ;
         endcase
      end
   end

   // Storage needs no reset: entries are only observed while counted as valid.
   always_ff @(posedge clk) begin
      if (rst && !flush_i && push) mem[wr_ptr] <= inst_i;
   end

   // ---------------- register file ----------------
   logic [31:0] regs [NUM_REGS];
   logic        wb_ok;

   assign wb_ok = wb_rd_write_en_i && (wb_rd_id_i != '0) && (NUM_REGS == 32 || !wb_rd_id_i[4]);

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wb_ok) begin
         regs[wb_rd_id_i[RIW-1:0]] <= wb_rd_write_data_i;
      end
   end

   logic [31:0] head, rs1_val, rs2_val;
   logic [4:0]  rs1_id, rs2_id, rd_id;
   logic [2:0]  f3;
   logic [6:0]  f7;

   assign head   = mem[rd_ptr];
   assign rs1_id = head[19:15];
   assign rs2_id = head[24:20];
   assign rd_id  = head[11:7];
   assign f3     = head[14:12];
   assign f7     = head[31:25];

   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (rs1_id != '0 && (NUM_REGS == 32 || !rs1_id[4])) rs1_val = regs[rs1_id[RIW-1:0]];
      if (rs2_id != '0 && (NUM_REGS == 32 || !rs2_id[4])) rs2_val = regs[rs2_id[RIW-1:0]];
`ifdef DECODE_QUEUE_WB_BYPASS_EN
      if (wb_ok && wb_rd_id_i == rs1_id) rs1_val = wb_rd_write_data_i;
      if (wb_ok && wb_rd_id_i == rs2_id) rs2_val = wb_rd_write_data_i;
`endif
   end

   // ---------------- decode of the head entry ----------------
   logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm;
   logic [9:0]  op;
   logic [5:0]  br, csr;
   logic [7:0]  ls;
   logic [2:0]  sys;
   logic        legal, use_rs1, use_rs2, use_rd, illegal;

   assign imm_i = {{20{head[31]}}, head[31:20]};
   assign imm_s = {{20{head[31]}}, head[31:25], head[11:7]};
   assign imm_b = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
   assign imm_j = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
   assign imm_u = {head[31:12], 12'b0};

   always_comb begin
      op      = '0;
      br      = '0;
      ls      = '0;
      csr     = '0;
      sys     = '0;
      imm     = '0;
      legal   = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      case (head[6:0])
         OPC_OP_IMM: begin
            op[9]   = 1'b1;
            legal   = (f3 == 3'd1) ? (f7 == 7'h00) :
                      (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            use_rs1 = 1'b1;
            use_rd  = 1'b1;
            imm     = imm_i;
         end
         OPC_OP: begin
            op[8]   = 1'b1;
            legal   = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            use_rd  = 1'b1;
         end
         OPC_LUI:   begin op[7] = 1'b1; legal = 1'b1; use_rd = 1'b1; imm = imm_u; end
         OPC_AUIPC: begin op[6] = 1'b1; legal = 1'b1; use_rd = 1'b1; imm = imm_u; end
         OPC_JAL:   begin op[5] = 1'b1; legal = 1'b1; use_rd = 1'b1; imm = imm_j; end
         OPC_JALR: begin
            op[4]   = 1'b1;
            legal   = (f3 == 3'd0);
            use_rs1 = 1'b1;
            use_rd  = 1'b1;
            imm     = imm_i;
         end
         OPC_BRANCH: begin
            op[3] = 1'b1;
            case (f3)
               3'd0: br[0] = 1'b1;
               3'd1: br[1] = 1'b1;
               3'd4: br[2] = 1'b1;
               3'd5: br[3] = 1'b1;
               3'd6: br[4] = 1'b1;
               3'd7: br[5] = 1'b1;
               default: ;
            endcase
            legal   = |br;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            imm     = imm_b;
         end
         OPC_LOAD: begin
            op[2] = 1'b1;
            case (f3)
               3'd0: ls[0] = 1'b1;
               3'd1: ls[1] = 1'b1;
               3'd2: ls[2] = 1'b1;
               3'd4: ls[3] = 1'b1;
               3'd5: ls[4] = 1'b1;
               default: ;
            endcase
            legal   = |ls;
            use_rs1 = 1'b1;
            use_rd  = 1'b1;
            imm     = imm_i;
         end
         OPC_STORE: begin
            op[1] = 1'b1;
            case (f3)
               3'd0: ls[5] = 1'b1;
               3'd1: ls[6] = 1'b1;
               3'd2: ls[7] = 1'b1;
               default: ;
            endcase
            legal   = |ls;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            imm     = imm_s;
         end
         OPC_SYSTEM: begin
            op[0] = 1'b1;
            if (f3 == 3'd0) begin
               // Privileged forms must match the whole word; other encodings are reserved.
               if (head == 32'h0000_0073)      sys[2] = 1'b1;
               else if (head == 32'h0010_0073) sys[1] = 1'b1;
               else if (head == 32'h3020_0073) sys[0] = 1'b1;
               legal = |sys;
            end else begin
               case (f3)
                  3'd1: csr[0] = 1'b1;
                  3'd2: csr[1] = 1'b1;
                  3'd3: csr[2] = 1'b1;
                  3'd5: csr[3] = 1'b1;
                  3'd6: csr[4] = 1'b1;
                  3'd7: csr[5] = 1'b1;
                  default: ;
               endcase
               legal   = |csr;
               use_rd  = 1'b1;
               use_rs1 = !f3[2];
            end
         end
         default: ;
      endcase
   end

   assign illegal = !legal ||
                    (NUM_REGS == 16 && ((use_rs1 && rs1_id[4]) || (use_rs2 && rs2_id[4]) ||
                                        (use_rd && rd_id[4])));

   always_comb begin
      decode_rs1_id_o          = '0;
      decode_rs2_id_o          = '0;
      decode_rd_id_o           = '0;
      decode_csr_id_o          = '0;
      decode_opcode_info_o     = '0;
      decode_branch_info_o     = '0;
      decode_load_store_info_o = '0;
      decode_csr_info_o        = '0;
      decode_sys_info_o        = '0;
      decode_illegal_o         = 1'b0;
      decode_rd_write_en_o     = 1'b0;
      decode_imm_o             = '0;
      regfile_rs1_rdata_o      = '0;
      regfile_rs2_rdata_o      = '0;
      if (out_valid_o) begin
         decode_rs1_id_o     = rs1_id;
         decode_rs2_id_o     = rs2_id;
         decode_rd_id_o      = rd_id;
         decode_csr_id_o     = head[31:20];
         decode_illegal_o    = illegal;
         regfile_rs1_rdata_o = rs1_val;
         regfile_rs2_rdata_o = rs2_val;
         if (!illegal) begin
            decode_opcode_info_o     = op;
            decode_branch_info_o     = br;
            decode_load_store_info_o = ls;
            decode_csr_info_o        = csr;
            decode_sys_info_o        = sys;
            decode_rd_write_en_o     = use_rd;
            decode_imm_o             = imm;
         end
      end
   end
endmodule
